// File: rtl/bcd_seg_display_pkg.sv
// Shared types and constants for the BCD 7-segment display block.
package bcd_seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam int IN_W       = 16;
  localparam int NIBBLES    = 5;             // 0..65535 needs five BCD digits
  localparam int SR_W       = 4*NIBBLES + IN_W;
  localparam int NUM_DIGITS = 4;             // only the low four are displayed

  // Segment patterns, lit = 1, bit order g..a
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Digit to active-high pattern; codes >= 10 cannot come out of the converter
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = SEG_0;
      4'd1:    seg_pattern = SEG_1;
      4'd2:    seg_pattern = SEG_2;
      4'd3:    seg_pattern = SEG_3;
      4'd4:    seg_pattern = SEG_4;
      4'd5:    seg_pattern = SEG_5;
      4'd6:    seg_pattern = SEG_6;
      4'd7:    seg_pattern = SEG_7;
      4'd8:    seg_pattern = SEG_8;
      4'd9:    seg_pattern = SEG_9;
      default: seg_pattern = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_seg_display_if.sv
// Valid/ready input channel carrying the 16-bit value to display.
interface bcd_seg_display_if;
  import bcd_seg_display_pkg::*;

  logic            in_valid;
  logic [IN_W-1:0] in_data;
  logic            in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/bcd_seg_display_seg7_encode.sv
// One BCD digit to seven segments, with blanking and output polarity.
module seg7_encode
  import bcd_seg_display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] lit;

  // Pick the lit pattern, then apply polarity
  always_comb begin
    lit = blank ? SEG_BLANK : seg_pattern(digit);
    seg = ACTIVE_LOW ? ~lit : lit;
  end

endmodule

// File: rtl/bcd_seg_display.sv
// 16-bit binary to four-digit 7-segment display via serial double dabble.
module bcd_seg_display
  import bcd_seg_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit BLANK_LEADING  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_seg_display_if.slave    bus,
  output logic [6:0]          hex3,
  output logic [6:0]          hex2,
  output logic [6:0]          hex1,
  output logic [6:0]          hex0,
  output logic                overflow,
  output logic                done
);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t                          state, state_nxt;
  logic [SR_W-1:0]                 sr, adj;
  logic [3:0]                      cnt;
  logic [NUM_DIGITS-1:0][3:0]      dig;
  logic [NUM_DIGITS-1:0]           lead;
  logic [NUM_DIGITS-1:0][6:0]      seg;
  logic                            ovf;

  assign bus.in_ready = (state == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Next state: 16 shift cycles then one commit cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = CONVERT;
      CONVERT: if (cnt == 4'd15) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble that would reach >= 10 after the shift
  always_comb begin
    adj = sr;
    for (int i = 0; i < NIBBLES; i++)
      if (sr[IN_W+4*i +: 4] >= 4'd5) adj[IN_W+4*i +: 4] = sr[IN_W+4*i +: 4] + 4'd3;
  end

  // Shift register and bit counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      sr  <= {{(4*NIBBLES){1'b0}}, bus.in_data};
      cnt <= '0;
    end else if (state == CONVERT) begin
      sr  <= adj << 1;
      cnt <= cnt + 4'd1;
    end

  // Digits and leading-zero blanking; a truncated (overflow) value is never blanked
  assign dig = sr[IN_W +: 4*NUM_DIGITS];
  assign ovf = |sr[SR_W-1 -: 4];

  always_comb begin
    lead[3] = BLANK_LEADING && !ovf && (dig[3] == 4'd0);
    lead[2] = lead[3] && (dig[2] == 4'd0);
    lead[1] = lead[2] && (dig[1] == 4'd0);
    lead[0] = 1'b0;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    seg7_encode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc (
      .digit (dig[g]),
      .blank (lead[g]),
      .seg   (seg[g])
    );
  end

  // Display registers: load on COMMIT, hold otherwise; done follows COMMIT by one edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hex3     <= SEG_OFF;
      hex2     <= SEG_OFF;
      hex1     <= SEG_OFF;
      hex0     <= SEG_OFF;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == COMMIT);
      if (state == COMMIT) begin
        hex3     <= seg[3];
        hex2     <= seg[2];
        hex1     <= seg[1];
        hex0     <= seg[0];
        overflow <= ovf;
      end
    end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Directed bench: default, active-low and leading-blank instances driven in lockstep.
module tb_bcd_seg_display;

  localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                         S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101,
                         S7 = 7'b0000111, S8 = 7'b1111111, S9 = 7'b1101111,
                         SB = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] data = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  bcd_seg_display_if if_n ();
  bcd_seg_display_if if_a ();
  bcd_seg_display_if if_b ();
  assign if_n.in_valid = valid;  assign if_n.in_data = data;
  assign if_a.in_valid = valid;  assign if_a.in_data = data;
  assign if_b.in_valid = valid;  assign if_b.in_data = data;

  logic [6:0] n3, n2, n1, n0, a3, a2, a1, a0, b3, b2, b1, b0;
  logic       n_ovf, n_done, a_ovf, a_done, b_ovf, b_done;

  bcd_seg_display #(.SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b0)) u_n (
    .clk(clk), .rst_n(rst_n), .bus(if_n.slave),
    .hex3(n3), .hex2(n2), .hex1(n1), .hex0(n0), .overflow(n_ovf), .done(n_done));
  bcd_seg_display #(.SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave),
    .hex3(a3), .hex2(a2), .hex1(a1), .hex0(a0), .overflow(a_ovf), .done(a_done));
  bcd_seg_display #(.SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave),
    .hex3(b3), .hex2(b2), .hex1(b1), .hex0(b0), .overflow(b_ovf), .done(b_done));

  // Advance one edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present v for one edge (E0), then run to just after E17
  task automatic send(input logic [15:0] v);
    valid = 1'b1;
    data  = v;
    tick();
    valid = 1'b0;
    repeat (17) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_chk++;
    if ({n3, n2, n1, n0} !== {4{SB}}) begin
      n_fail++; $display("FAIL reset_hex got=%h exp=%h", {n3, n2, n1, n0}, {4{SB}});
    end
    n_chk++;
    if ({a3, a2, a1, a0} !== {4{7'h7F}}) begin
      n_fail++; $display("FAIL reset_hex_al got=%h exp=%h", {a3, a2, a1, a0}, {4{7'h7F}});
    end
    n_chk++;
    if ({if_n.in_ready, n_ovf, n_done} !== 3'b100) begin
      n_fail++; $display("FAIL reset_ctl got=%b exp=100", {if_n.in_ready, n_ovf, n_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    logic busy_ok = 1'b1;
    valid = 1'b1;
    data  = 16'd1234;
    tick();                         // E0
    valid = 1'b0;
    if (if_n.in_ready !== 1'b0 || n_done !== 1'b0) busy_ok = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (if_n.in_ready !== 1'b0 || n_done !== 1'b0) busy_ok = 1'b0;
    end
    n_chk++;
    if (!busy_ok) begin
      n_fail++; $display("FAIL busy_window got=%b exp=1", busy_ok);
    end
    n_chk++;
    if ({n3, n2, n1, n0} !== {4{SB}}) begin
      n_fail++; $display("FAIL hold_before_e17 got=%h exp=%h", {n3, n2, n1, n0}, {4{SB}});
    end
    tick();                         // E17
    n_chk++;
    if ({n3, n2, n1, n0} !== {S1, S2, S3, S4}) begin
      n_fail++; $display("FAIL hex_1234 got=%h exp=%h", {n3, n2, n1, n0}, {S1, S2, S3, S4});
    end
    n_chk++;
    if ({n_done, n_ovf, if_n.in_ready} !== 3'b101) begin
      n_fail++; $display("FAIL ctl_1234 got=%b exp=101", {n_done, n_ovf, if_n.in_ready});
    end
    n_chk++;
    if ({a3, a2, a1, a0} !== ~{S1, S2, S3, S4}) begin
      n_fail++; $display("FAIL hex_1234_al got=%h exp=%h", {a3, a2, a1, a0}, ~{S1, S2, S3, S4});
    end
    repeat (3) tick();
    n_chk++;
    if ({n_done, n3, n0} !== {1'b0, S1, S4}) begin
      n_fail++; $display("FAIL done_pulse_hold got=%h exp=%h", {n_done, n3, n0}, {1'b0, S1, S4});
    end
  endtask

  task automatic test_overflow();
    send(16'd65535);
    n_chk++;
    if ({n3, n2, n1, n0, n_ovf} !== {S5, S5, S3, S5, 1'b1}) begin
      n_fail++; $display("FAIL hex_65535 got=%h exp=%h", {n3, n2, n1, n0, n_ovf}, {S5, S5, S3, S5, 1'b1});
    end
    send(16'd10005);
    n_chk++;
    if ({b3, b2, b1, b0, b_ovf} !== {S0, S0, S0, S5, 1'b1}) begin
      n_fail++; $display("FAIL ovf_no_blank got=%h exp=%h", {b3, b2, b1, b0, b_ovf}, {S0, S0, S0, S5, 1'b1});
    end
    send(16'd0);
    n_chk++;
    if ({n3, n2, n1, n0, n_ovf} !== {S0, S0, S0, S0, 1'b0}) begin
      n_fail++; $display("FAIL hex_0 got=%h exp=%h", {n3, n2, n1, n0, n_ovf}, {S0, S0, S0, S0, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    int waited = 0;
    valid = 1'b1;
    data  = 16'd42;
    tick();                         // E0
    valid = 1'b0;
    repeat (4) tick();              // E1..E4
    valid = 1'b1;
    data  = 16'd9999;               // held from E5 on
    repeat (13) tick();             // E5..E17
    n_chk++;
    if ({n3, n2, n1, n0, n_done} !== {S0, S0, S4, S2, 1'b1}) begin
      n_fail++; $display("FAIL hex_0042 got=%h exp=%h", {n3, n2, n1, n0, n_done}, {S0, S0, S4, S2, 1'b1});
    end
    tick();
    while (n_done !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    valid = 1'b0;
    n_chk++;
    if (n_done !== 1'b1) begin
      n_fail++; $display("FAIL repeat_done_timeout got=%b exp=1", n_done);
    end
    n_chk++;
    if ({n3, n2, n1, n0} !== {4{S9}}) begin
      n_fail++; $display("FAIL hex_9999 got=%h exp=%h", {n3, n2, n1, n0}, {4{S9}});
    end
    repeat (2) tick();
  endtask

  task automatic test_blank_leading();
    send(16'd7);
    n_chk++;
    if ({b3, b2, b1, b0} !== {SB, SB, SB, S7}) begin
      n_fail++; $display("FAIL blank_7 got=%h exp=%h", {b3, b2, b1, b0}, {SB, SB, SB, S7});
    end
    n_chk++;
    if ({n3, n2, n1, n0} !== {S0, S0, S0, S7}) begin
      n_fail++; $display("FAIL noblank_7 got=%h exp=%h", {n3, n2, n1, n0}, {S0, S0, S0, S7});
    end
    send(16'd0);
    n_chk++;
    if ({b3, b2, b1, b0} !== {SB, SB, SB, S0}) begin
      n_fail++; $display("FAIL blank_0 got=%h exp=%h", {b3, b2, b1, b0}, {SB, SB, SB, S0});
    end
    send(16'd1005);
    n_chk++;
    if ({b3, b2, b1, b0} !== {S1, S0, S0, S5}) begin
      n_fail++; $display("FAIL blank_1005 got=%h exp=%h", {b3, b2, b1, b0}, {S1, S0, S0, S5});
    end
    send(16'd40);
    n_chk++;
    if ({b3, b2, b1, b0} !== {SB, SB, S4, S0}) begin
      n_fail++; $display("FAIL blank_40 got=%h exp=%h", {b3, b2, b1, b0}, {SB, SB, S4, S0});
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done = 1'b0;
    send(16'd8888);
    n_chk++;
    if ({n3, n2, n1, n0} !== {4{S8}}) begin
      n_fail++; $display("FAIL hex_8888 got=%h exp=%h", {n3, n2, n1, n0}, {4{S8}});
    end
    valid = 1'b1;
    data  = 16'd1111;
    tick();                         // E0
    valid = 1'b0;
    repeat (7) tick();              // E1..E7
    @(posedge clk);                 // E8
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({n3, n2, n1, n0} !== {4{SB}}) begin
      n_fail++; $display("FAIL async_blank got=%h exp=%h", {n3, n2, n1, n0}, {4{SB}});
    end
    n_chk++;
    if ({a3, a2, a1, a0} !== {4{7'h7F}}) begin
      n_fail++; $display("FAIL async_blank_al got=%h exp=%h", {a3, a2, a1, a0}, {4{7'h7F}});
    end
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (n_done !== 1'b0) saw_done = 1'b1;
    end
    n_chk++;
    if (saw_done !== 1'b0) begin
      n_fail++; $display("FAIL no_done_after_abort got=%b exp=0", saw_done);
    end
    n_chk++;
    if ({if_n.in_ready, n3, n2, n1, n0} !== {1'b1, {4{SB}}}) begin
      n_fail++; $display("FAIL post_abort got=%h exp=%h", {if_n.in_ready, n3, n2, n1, n0}, {1'b1, {4{SB}}});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_blank_leading();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
